// File: rtl/bus_arb_pkg.sv
// Shared definitions for the system-bus host arbiter.
//   arb_state_e      : arbiter FSM states
//   TMO_CNT_W        : width of the response-timeout counter
//   FORCED_ERR_RDATA : read data returned with a forced timeout error
package bus_arb_pkg;

    typedef enum logic {
        IDLE     = 1'b0,
        WAIT_RSP = 1'b1
    } arb_state_e;

    localparam int TMO_CNT_W = 16;

    localparam logic [31:0] FORCED_ERR_RDATA = 32'h0;

endpackage

// File: rtl/bus_host_arbiter_rr_arbiter.sv
// Combinational round-robin pick.
//   i_req    : request vector, one bit per requester
//   i_rr_ptr : highest-priority requester index for this pick
//   o_gnt    : one-hot grant (all zero when nobody requests)
//   o_idx    : binary index of the granted requester (0 when nobody requests)
module rr_arbiter #(
    parameter int N  = 2,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  i_req,
    input  logic [IW-1:0] i_rr_ptr,
    output logic [N-1:0]  o_gnt,
    output logic [IW-1:0] o_idx
);

    int w_best;
    int w_dist;

    // The winner is the requester with the smallest circular distance from
    // the pointer, which is the first one met when scanning ptr, ptr+1, ...
    always_comb begin
        o_idx  = '0;
        w_best = N;
        w_dist = 0;
        for (int h = 0; h < N; h++) begin
            w_dist = (h + N - int'(i_rr_ptr)) % N;
            if (i_req[h] && (w_dist < w_best)) begin
                w_best = w_dist;
                o_idx  = IW'(h);
            end
        end
        o_gnt = (w_best < N) ? (N'(1) << o_idx) : '0;
    end

endmodule

// File: rtl/bus_host_arbiter.sv
// Round-robin arbiter sharing the single system-bus host port among
// NrHosts masters, one outstanding transaction at a time.
//   clk_i, rst_i        : clock, asynchronous active-high reset
//   host_req_i/gnt_o    : per-host request / grant
//   host_addr/we/be/wdata_i : packed per-host payload, host h at slice h
//   host_rvalid_o/err_o : per-host response valid / error (owner only)
//   host_rdata_o        : read data broadcast to all hosts
//   dev_req_o/gnt_i     : bus request / grant
//   dev_addr/we/be/wdata_o : payload of the selected host
//   dev_rvalid/rdata/err_i : bus response
//   stray_rsp_o         : pulse when a response arrives with no owner
//
// Handshake: a host holds req and payload until it sees its grant bit.
// A grant is dev_gnt_i in a cycle where dev_req_o is high in IDLE; the
// response is the first dev_rvalid_i cycle afterwards, or a forced error
// after TimeoutCycles silent cycles.
module bus_host_arbiter
    import bus_arb_pkg::*;
#(
    parameter int NrHosts       = 2,
    parameter int DataWidth     = 32,
    parameter int AddressWidth  = 32,
    parameter int TimeoutCycles = 255
) (
    input  logic                            clk_i,
    input  logic                            rst_i,
    input  logic [NrHosts-1:0]              host_req_i,
    output logic [NrHosts-1:0]              host_gnt_o,
    input  logic [NrHosts*AddressWidth-1:0] host_addr_i,
    input  logic [NrHosts-1:0]              host_we_i,
    input  logic [NrHosts*4-1:0]            host_be_i,
    input  logic [NrHosts*DataWidth-1:0]    host_wdata_i,
    output logic [NrHosts-1:0]              host_rvalid_o,
    output logic [DataWidth-1:0]            host_rdata_o,
    output logic [NrHosts-1:0]              host_err_o,
    output logic                            dev_req_o,
    input  logic                            dev_gnt_i,
    output logic [AddressWidth-1:0]         dev_addr_o,
    output logic                            dev_we_o,
    output logic [3:0]                      dev_be_o,
    output logic [DataWidth-1:0]            dev_wdata_o,
    input  logic                            dev_rvalid_i,
    input  logic [DataWidth-1:0]            dev_rdata_i,
    input  logic                            dev_err_i,
    output logic                            stray_rsp_o
);

    localparam int IdxW = (NrHosts > 1) ? $clog2(NrHosts) : 1;

    arb_state_e           r_state;
    arb_state_e           w_next_state;
    logic [IdxW-1:0]      r_rr_ptr;
    logic [IdxW-1:0]      r_owner;
    logic                 r_hold;
    logic [TMO_CNT_W-1:0] r_tmo_cnt;

    logic [NrHosts-1:0]   w_arb_gnt;
    logic [IdxW-1:0]      w_arb_idx;
    logic [IdxW-1:0]      w_winner;
    logic [IdxW-1:0]      w_next_ptr;
    logic                 w_any;
    logic                 w_tmo_hit;

    rr_arbiter #(
        .N  (NrHosts),
        .IW (IdxW)
    ) u_rr_arbiter (
        .i_req    (host_req_i),
        .i_rr_ptr (r_rr_ptr),
        .o_gnt    (w_arb_gnt),
        .o_idx    (w_arb_idx)
    );

    // Once a stalled request has been presented, the latched owner keeps
    // the bus so the payload seen by the device cannot change under it.
    assign w_winner   = r_hold ? r_owner : w_arb_idx;
    assign w_any      = r_hold | (|w_arb_gnt);
    assign w_tmo_hit  = (r_tmo_cnt == TMO_CNT_W'(TimeoutCycles - 1));
    assign w_next_ptr = (w_winner == IdxW'(NrHosts - 1)) ? '0 : w_winner + 1'b1;

    // State register
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE: begin
                if (w_any && dev_gnt_i) begin
                    w_next_state = WAIT_RSP;
                end
            end
            WAIT_RSP: begin
                if (dev_rvalid_i || w_tmo_hit) begin
                    w_next_state = IDLE;
                end
            end
            default: w_next_state = IDLE;
        endcase
    end

    // Hold/owner/pointer/timeout registers
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_rr_ptr  <= '0;
            r_owner   <= '0;
            r_hold    <= 1'b0;
            r_tmo_cnt <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_any && dev_gnt_i) begin
                        r_owner   <= w_winner;
                        r_hold    <= 1'b0;
                        r_rr_ptr  <= w_next_ptr;
                        r_tmo_cnt <= '0;
                    end else if (w_any) begin
                        r_owner <= w_winner;
                        r_hold  <= 1'b1;
                    end
                end
                WAIT_RSP: begin
                    if (r_tmo_cnt != '1) begin
                        r_tmo_cnt <= r_tmo_cnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Output logic. Outputs are forced low while reset is asserted so an
    // abandoned transaction is visibly dropped at once.
    always_comb begin
        host_gnt_o    = '0;
        host_rvalid_o = '0;
        host_err_o    = '0;
        host_rdata_o  = '0;
        dev_req_o     = 1'b0;
        dev_addr_o    = '0;
        dev_we_o      = 1'b0;
        dev_be_o      = '0;
        dev_wdata_o   = '0;
        stray_rsp_o   = 1'b0;
        if (!rst_i) begin
            case (r_state)
                IDLE: begin
                    dev_req_o   = w_any;
                    stray_rsp_o = dev_rvalid_i;
                    if (w_any) begin
                        dev_addr_o           = host_addr_i[w_winner*AddressWidth +: AddressWidth];
                        dev_we_o             = host_we_i[w_winner];
                        dev_be_o             = host_be_i[w_winner*4 +: 4];
                        dev_wdata_o          = host_wdata_i[w_winner*DataWidth +: DataWidth];
                        host_gnt_o[w_winner] = dev_gnt_i;
                    end
                end
                WAIT_RSP: begin
                    // A real response in the terminal cycle beats the timeout.
                    if (dev_rvalid_i) begin
                        host_rvalid_o[r_owner] = 1'b1;
                        host_err_o[r_owner]    = dev_err_i;
                        host_rdata_o           = dev_rdata_i;
                    end else if (w_tmo_hit) begin
                        host_rvalid_o[r_owner] = 1'b1;
                        host_err_o[r_owner]    = 1'b1;
                        host_rdata_o           = DataWidth'(FORCED_ERR_RDATA);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_bus_host_arbiter.sv
module tb_bus_host_arbiter;

  localparam int NH  = 2;
  localparam int DW  = 32;
  localparam int AW  = 32;
  localparam int TMO = 8;

  logic            clk;
  logic            rst;
  logic [NH-1:0]   host_req_i;
  logic [NH-1:0]   host_gnt_o;
  logic [NH*AW-1:0] host_addr_i;
  logic [NH-1:0]   host_we_i;
  logic [NH*4-1:0] host_be_i;
  logic [NH*DW-1:0] host_wdata_i;
  logic [NH-1:0]   host_rvalid_o;
  logic [DW-1:0]   host_rdata_o;
  logic [NH-1:0]   host_err_o;
  logic            dev_req_o;
  logic            dev_gnt_i;
  logic [AW-1:0]   dev_addr_o;
  logic            dev_we_o;
  logic [3:0]      dev_be_o;
  logic [DW-1:0]   dev_wdata_o;
  logic            dev_rvalid_i;
  logic [DW-1:0]   dev_rdata_i;
  logic            dev_err_i;
  logic            stray_rsp_o;

  int errors = 0;
  int checks = 0;

  bus_host_arbiter #(
    .NrHosts       (NH),
    .DataWidth     (DW),
    .AddressWidth  (AW),
    .TimeoutCycles (TMO)
  ) dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .host_req_i    (host_req_i),
    .host_gnt_o    (host_gnt_o),
    .host_addr_i   (host_addr_i),
    .host_we_i     (host_we_i),
    .host_be_i     (host_be_i),
    .host_wdata_i  (host_wdata_i),
    .host_rvalid_o (host_rvalid_o),
    .host_rdata_o  (host_rdata_o),
    .host_err_o    (host_err_o),
    .dev_req_o     (dev_req_o),
    .dev_gnt_i     (dev_gnt_i),
    .dev_addr_o    (dev_addr_o),
    .dev_we_o      (dev_we_o),
    .dev_be_o      (dev_be_o),
    .dev_wdata_o   (dev_wdata_o),
    .dev_rvalid_i  (dev_rvalid_i),
    .dev_rdata_i   (dev_rdata_i),
    .dev_err_i     (dev_err_i),
    .stray_rsp_o   (stray_rsp_o)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  // Transaction-level view: either a transaction is outstanding (m_busy)
  // for m_owner, or the bus is free and the next winner is chosen from the
  // round-robin pointer unless a stalled winner is being held.
  bit m_busy;
  bit m_hold;
  int m_ptr;
  int m_owner;
  int m_silent;

  task automatic model_reset();
    m_busy   = 0;
    m_hold   = 0;
    m_ptr    = 0;
    m_owner  = 0;
    m_silent = 0;
  endtask

  function automatic int rr_pick();
    for (int k = 0; k < NH; k++) begin
      if (host_req_i[(m_ptr + k) % NH]) return (m_ptr + k) % NH;
    end
    return 0;
  endfunction

  function automatic bit free_any();
    return m_hold || (host_req_i != '0);
  endfunction

  function automatic int free_winner();
    return m_hold ? m_owner : rr_pick();
  endfunction

  // ---------------- checker ----------------
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Compare every output against the model for the inputs now applied.
  task automatic look();
    logic [NH-1:0] e_gnt, e_rv, e_err;
    logic [AW-1:0] e_addr;
    logic [DW-1:0] e_wd, e_rd;
    logic [3:0]    e_be;
    logic          e_req, e_we, e_stray;
    int            win;
    #1;
    e_gnt = '0; e_rv = '0; e_err = '0; e_addr = '0; e_wd = '0; e_rd = '0;
    e_be = '0; e_req = 1'b0; e_we = 1'b0; e_stray = 1'b0;
    if (!rst) begin
      if (!m_busy) begin
        e_stray = dev_rvalid_i;
        if (free_any()) begin
          win    = free_winner();
          e_req  = 1'b1;
          e_addr = host_addr_i[win*AW +: AW];
          e_we   = host_we_i[win];
          e_be   = host_be_i[win*4 +: 4];
          e_wd   = host_wdata_i[win*DW +: DW];
          e_gnt[win] = dev_gnt_i;
        end
      end else if (dev_rvalid_i) begin
        e_rv[m_owner]  = 1'b1;
        e_err[m_owner] = dev_err_i;
        e_rd           = dev_rdata_i;
      end else if (m_silent == TMO - 1) begin
        e_rv[m_owner]  = 1'b1;
        e_err[m_owner] = 1'b1;
      end
    end
    chk("dev_req", 64'(dev_req_o), 64'(e_req));
    chk("dev_addr", 64'(dev_addr_o), 64'(e_addr));
    chk("dev_we", 64'(dev_we_o), 64'(e_we));
    chk("dev_be", 64'(dev_be_o), 64'(e_be));
    chk("dev_wdata", 64'(dev_wdata_o), 64'(e_wd));
    chk("host_gnt", 64'(host_gnt_o), 64'(e_gnt));
    chk("host_rvalid", 64'(host_rvalid_o), 64'(e_rv));
    chk("host_err", 64'(host_err_o & host_rvalid_o), 64'(e_err));
    chk("host_rdata", 64'(host_rdata_o), 64'(e_rd));
    chk("stray", 64'(stray_rsp_o), 64'(e_stray));
  endtask

  // Advance one clock and move the model across the same edge.
  task automatic adv();
    int win;
    @(posedge clk);
    if (rst) begin
      model_reset();
    end else if (!m_busy) begin
      if (free_any()) begin
        win = free_winner();
        if (dev_gnt_i) begin
          m_busy   = 1;
          m_hold   = 0;
          m_owner  = win;
          m_ptr    = (win + 1) % NH;
          m_silent = 0;
        end else begin
          m_hold  = 1;
          m_owner = win;
        end
      end
    end else if (dev_rvalid_i || m_silent == TMO - 1) begin
      m_busy = 0;
    end else begin
      m_silent++;
    end
    #1;
  endtask

  // ---------------- driver helpers ----------------
  task automatic set_host(input int h, input logic [AW-1:0] a, input logic we,
                          input logic [3:0] be, input logic [DW-1:0] wd);
    host_addr_i[h*AW +: AW]  = a;
    host_we_i[h]             = we;
    host_be_i[h*4 +: 4]      = be;
    host_wdata_i[h*DW +: DW] = wd;
  endtask

  task automatic clear_dev();
    dev_gnt_i    = 1'b0;
    dev_rvalid_i = 1'b0;
    dev_rdata_i  = '0;
    dev_err_i    = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [NH-1:0] pend;
    logic [NH-1:0] g;
    int exp_h;

    rst = 1'b1;
    host_req_i = 2'b11;
    host_addr_i = '0; host_we_i = '0; host_be_i = '0; host_wdata_i = '0;
    set_host(0, 32'h1111_0000, 1'b1, 4'hF, 32'h1);
    set_host(1, 32'h2222_0000, 1'b1, 4'hF, 32'h2);
    clear_dev();
    dev_gnt_i = 1'b1;
    dev_rvalid_i = 1'b1;
    model_reset();

    // Reset: every output low even with live inputs.
    look();
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
    host_req_i = '0;
    clear_dev();

    // Single read by host0, granted one cycle late, answered two cycles after grant.
    set_host(0, 32'h0010_0010, 1'b0, 4'hF, 32'h0);
    host_req_i[0] = 1'b1;
    look(); adv();
    dev_gnt_i = 1'b1;
    look(); chk("t1_gnt", 64'(host_gnt_o), 64'h1); adv();
    host_req_i = '0; dev_gnt_i = 1'b0;
    look(); chk("t1_wait_rv", 64'(host_rvalid_o), 64'h0); adv();
    dev_rvalid_i = 1'b1; dev_rdata_i = 32'hCAFE_F00D;
    look();
    chk("t1_rvalid", 64'(host_rvalid_o), 64'h1);
    chk("t1_rdata", 64'(host_rdata_o), 64'hCAFE_F00D);
    adv();
    clear_dev();
    look(); chk("t1_after_rv", 64'(host_rvalid_o), 64'h0); adv();

    // Both hosts requesting continuously; host0 was served last so host1 goes first.
    set_host(0, 32'h0000_0A00, 1'b0, 4'hF, 32'h0);
    set_host(1, 32'h0000_0B00, 1'b0, 4'hF, 32'h0);
    host_req_i = 2'b11;
    exp_h = 1;
    for (int n = 0; n < 4; n++) begin
      dev_gnt_i = 1'b1; dev_rvalid_i = 1'b0;
      look(); chk("alt_gnt", 64'(host_gnt_o), 64'(1 << exp_h)); adv();
      dev_rvalid_i = 1'b1; dev_rdata_i = $urandom;
      look();
      chk("alt_rsp", 64'(host_rvalid_o), 64'(1 << exp_h));
      chk("alt_bubble", 64'(host_gnt_o), 64'h0);
      adv();
      exp_h = 1 - exp_h;
    end
    host_req_i = '0;
    clear_dev();

    // Timeout: host1 granted, device silent.
    set_host(1, 32'h0000_7000, 1'b0, 4'h1, 32'h0);
    host_req_i[1] = 1'b1; dev_gnt_i = 1'b1;
    look(); chk("tmo_gnt", 64'(host_gnt_o), 64'h2); adv();
    host_req_i = '0; dev_gnt_i = 1'b0;
    for (int k = 1; k <= TMO; k++) begin
      look();
      if (k < TMO) begin
        chk("tmo_early", 64'(host_rvalid_o), 64'h0);
      end else begin
        chk("tmo_rvalid", 64'(host_rvalid_o), 64'h2);
        chk("tmo_err", 64'(host_err_o), 64'h2);
        chk("tmo_rdata", 64'(host_rdata_o), 64'h0);
      end
      adv();
    end
    dev_rvalid_i = 1'b1; dev_rdata_i = 32'hDEAD_BEEF;
    look();
    chk("stray_pulse", 64'(stray_rsp_o), 64'h1);
    chk("stray_no_rv", 64'(host_rvalid_o), 64'h0);
    adv();
    clear_dev();
    look(); chk("stray_clear", 64'(stray_rsp_o), 64'h0); adv();

    // Stall: host1 requests, no grant for 5 cycles, host0 joins in cycle 2.
    set_host(1, 32'hA1A1_0004, 1'b0, 4'hF, 32'h0);
    host_req_i[1] = 1'b1;
    for (int c = 1; c <= 5; c++) begin
      if (c == 2) begin
        set_host(0, 32'hB0B0_0008, 1'b1, 4'h3, 32'h1234_5678);
        host_req_i[0] = 1'b1;
      end
      look(); chk("stall_addr", 64'(dev_addr_o), 64'hA1A1_0004); adv();
    end
    dev_gnt_i = 1'b1;
    look(); chk("stall_gnt", 64'(host_gnt_o), 64'h2); adv();
    host_req_i[1] = 1'b0; dev_gnt_i = 1'b0;
    dev_rvalid_i = 1'b1;
    look(); adv();
    clear_dev();

    // Write by host0 answered with a bus error.
    dev_gnt_i = 1'b1;
    look();
    chk("wr_gnt", 64'(host_gnt_o), 64'h1);
    chk("wr_we", 64'(dev_we_o), 64'h1);
    chk("wr_wdata", 64'(dev_wdata_o), 64'h1234_5678);
    adv();
    host_req_i = '0; dev_gnt_i = 1'b0;
    dev_rvalid_i = 1'b1; dev_err_i = 1'b1;
    look();
    chk("wr_rvalid", 64'(host_rvalid_o), 64'h1);
    chk("wr_err", 64'(host_err_o), 64'h1);
    adv();
    clear_dev();
    set_host(1, 32'h0000_C000, 1'b0, 4'hF, 32'h0);
    host_req_i[1] = 1'b1; dev_gnt_i = 1'b1;
    look(); chk("wr_back_idle", 64'(host_gnt_o), 64'h2); adv();
    host_req_i = '0; dev_gnt_i = 1'b0;

    // Reset in the second WAIT_RSP cycle.
    look(); adv();
    host_req_i = 2'b11; dev_gnt_i = 1'b1; dev_rvalid_i = 1'b1;
    rst = 1'b1;
    look();
    chk("rst_gnt", 64'(host_gnt_o), 64'h0);
    chk("rst_req", 64'(dev_req_o), 64'h0);
    chk("rst_rvalid", 64'(host_rvalid_o), 64'h0);
    adv();
    rst = 1'b0; dev_rvalid_i = 1'b0;
    look(); chk("rst_first_host0", 64'(host_gnt_o), 64'h1); adv();
    host_req_i = '0; dev_gnt_i = 1'b0;
    dev_rvalid_i = 1'b1;
    look(); adv();
    clear_dev();

    // Randomized traffic against the model.
    pend = '0;
    for (int cyc = 0; cyc < 2000; cyc++) begin
      for (int h = 0; h < NH; h++) begin
        if (!pend[h] && $urandom_range(0, 3) == 0) begin
          pend[h] = 1'b1;
          host_req_i[h] = 1'b1;
          set_host(h, $urandom, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), $urandom);
        end
      end
      dev_gnt_i    = 1'($urandom_range(0, 1));
      dev_rvalid_i = m_busy ? ($urandom_range(0, 4) == 0) : ($urandom_range(0, 29) == 0);
      dev_rdata_i  = $urandom;
      dev_err_i    = 1'($urandom_range(0, 1));
      look();
      g = host_gnt_o;
      adv();
      host_req_i = host_req_i & ~g;
      pend = pend & ~g;
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
